int_issue_stage_reg: RTL and testbench
======================================

Name: int_issue_stage_reg

Overview:
- Pipeline register between the schedule stage and the integer issue stage.
- Latches each lane the scheduler selects (valid, issue-queue pointer, active-list pointer, payload) and holds it under stall.
- Kills lanes selectively on misprediction recovery using active-list age, and reports killed lanes so the issue queue can release entries.
- One instance per integer issue group; memory, complex and FP lanes reuse it with different parameters.

Parameters:
- ISSUE_WIDTH, 2, number of lanes.
- AL_PTR_W, 6, active-list index width (64 entries).
- IQ_PTR_W, 6, issue-queue index width.
- PAYLOAD_W, 64, opaque per-lane op payload (not interpreted).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sch_valid  in  ISSUE_WIDTH  lane valid from scheduler
- sch_iq_ptr  in  ISSUE_WIDTH*IQ_PTR_W  issue-queue entry per lane
- sch_al_ptr  in  ISSUE_WIDTH*AL_PTR_W  active-list entry per lane
- sch_payload  in  ISSUE_WIDTH*PAYLOAD_W  op payload per lane
- stall  in  1  hold register contents
- flush  in  1  selective recovery request
- flush_all  in  1  kill every lane unconditionally
- flush_inclusive  in  1  also kill the lane whose age equals flush_al_ptr
- flush_al_ptr  in  AL_PTR_W  recovery point
- al_head_ptr  in  AL_PTR_W  active-list head (oldest op)
- iss_valid  out  ISSUE_WIDTH  registered lane valid
- iss_iq_ptr  out  ISSUE_WIDTH*IQ_PTR_W  registered
- iss_al_ptr  out  ISSUE_WIDTH*AL_PTR_W  registered
- iss_payload  out  ISSUE_WIDTH*PAYLOAD_W  registered
- kill_mask  out  ISSUE_WIDTH  lanes killed in the previous cycle
- kill_iq_ptr  out  ISSUE_WIDTH*IQ_PTR_W  IQ pointer of each killed lane
- valid_count  out  $clog2(ISSUE_WIDTH+1)  popcount of iss_valid, registered

Behaviour:
- Reset, synchronous on clk when rst=1:
  - All outputs go to 0.
  - rst overrides stall, flush and flush_all.
- Age, unsigned modulo 2^AL_PTR_W: age(p) = (p - al_head_ptr).
  - Lane is doomed when flush=1 and age(lane) > age(flush_al_ptr), or age(lane) == age(flush_al_ptr) with flush_inclusive=1.
  - Lane is also doomed whenever flush_all=1.
  - The modulo rule handles wrap: head=62 and ptr=1 gives age 3.
- Capture source for the next state, per lane:
  - stall=0: the incoming sch_* lane.
  - stall=1: the currently held iss_* lane.
- Kill: if the capture source is valid and doomed, the next iss_valid for that lane is 0.
  - Payload and pointers may update but are don't-care while valid is 0.
  - The lane's kill_mask bit is set next cycle, and kill_iq_ptr takes the source's IQ pointer.
- Stall with no kill: every iss_* output holds exactly. sch_* is ignored and must be held by the scheduler.
- Flush during stall: held lanes are killed, not held. This is the only way a stalled register changes.
- Flush with stall=0: incoming lanes are filtered by the same age rule in the same cycle.
- kill_mask is a one-cycle pulse per kill event and is 0 in every cycle with no kill.
  - A lane killed while stalled is reported exactly once. The next cycle its valid is 0, so it cannot be re-killed.
- Latency: sch_* to iss_* is 1 cycle.
- valid_count equals the popcount of the iss_valid register, updated in the same cycle.
- No combinational path from flush inputs to any output; all outputs are flops.
- Invalid inputs (sch_valid=0) never set kill_mask, even when their pointers match.

Test Plan:
- Reset: pulse rst with sch_valid=2'b11 -> next cycle iss_valid=0, kill_mask=0, valid_count=0. After release, sch_valid=2'b01 with al_ptr 5 -> iss_valid=2'b01, iss_al_ptr lane0=5, valid_count=1.
- Stall hold: latch lanes {al 3, al 4}, then assert stall 3 cycles while changing sch_* -> iss_* unchanged all 3 cycles. Drop stall -> new sch_* appears 1 cycle later.
- Selective flush with wrap: head=62, held lanes al_ptr {63, 1}, flush_al_ptr=0, flush_inclusive=0 -> lane1 killed (age 3 > 2), lane0 kept (age 1). kill_mask=2'b10 for exactly 1 cycle with lane1's IQ pointer.
- Inclusive boundary: lane al_ptr 10 equals flush_al_ptr 10, head 8 -> killed when flush_inclusive=1, kept when flush_inclusive=0.
- Flush during stall plus flush on incoming:
  - stall=1, held {al 20, al 21}, flush_all=1 -> iss_valid=0, kill_mask=2'b11 for one cycle. Holding stall and flush_all asserted the next cycle -> kill_mask=0.
  - stall=0, incoming {al 7, al 9}, head=0, flush_al_ptr=8 -> iss_valid=2'b01, kill_mask=2'b10.
- rst together with flush_all and stall -> all outputs 0, kill_mask=0.

Source files
------------

// File: rtl/int_issue_stage_reg_if.sv
// Schedule-to-issue bundle for int_issue_stage_reg: scheduler lanes, recovery
// controls and the registered issue/kill outputs.
interface int_issue_stage_reg_if #(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned AL_PTR_W    = 6,
    parameter int unsigned IQ_PTR_W    = 6,
    parameter int unsigned PAYLOAD_W   = 64
);
    localparam int unsigned CNT_W = $clog2(ISSUE_WIDTH + 1);

    logic [ISSUE_WIDTH-1:0]           sch_valid;
    logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  sch_iq_ptr;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0]  sch_al_ptr;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] sch_payload;
    logic                             stall;
    logic                             flush;
    logic                             flush_all;
    logic                             flush_inclusive;
    logic [AL_PTR_W-1:0]              flush_al_ptr;
    logic [AL_PTR_W-1:0]              al_head_ptr;

    logic [ISSUE_WIDTH-1:0]           iss_valid;
    logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  iss_iq_ptr;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0]  iss_al_ptr;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] iss_payload;
    logic [ISSUE_WIDTH-1:0]           kill_mask;
    logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  kill_iq_ptr;
    logic [CNT_W-1:0]                 valid_count;

    modport master (
        output sch_valid, sch_iq_ptr, sch_al_ptr, sch_payload,
        output stall, flush, flush_all, flush_inclusive, flush_al_ptr, al_head_ptr,
        input  iss_valid, iss_iq_ptr, iss_al_ptr, iss_payload,
        input  kill_mask, kill_iq_ptr, valid_count
    );

    modport slave (
        input  sch_valid, sch_iq_ptr, sch_al_ptr, sch_payload,
        input  stall, flush, flush_all, flush_inclusive, flush_al_ptr, al_head_ptr,
        output iss_valid, iss_iq_ptr, iss_al_ptr, iss_payload,
        output kill_mask, kill_iq_ptr, valid_count
    );
endinterface

// File: rtl/int_issue_stage_reg.sv
// Schedule->integer-issue pipeline register with stall hold and age-based
// selective kill on misprediction recovery; all outputs are flops.
module int_issue_stage_reg #(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned AL_PTR_W    = 6,
    parameter int unsigned IQ_PTR_W    = 6,
    parameter int unsigned PAYLOAD_W   = 64
) (
    input logic                  clk,
    input logic                  rst,
    int_issue_stage_reg_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(ISSUE_WIDTH + 1);

    logic [ISSUE_WIDTH-1:0]           r_iss_valid;
    logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  r_iss_iq_ptr;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0]  r_iss_al_ptr;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] r_iss_payload;
    logic [ISSUE_WIDTH-1:0]           r_kill_mask;
    logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  r_kill_iq_ptr;
    logic [CNT_W-1:0]                 r_valid_count;

    logic [ISSUE_WIDTH-1:0]           w_src_valid;
    logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  w_src_iq_ptr;
    logic [ISSUE_WIDTH*AL_PTR_W-1:0]  w_src_al_ptr;
    logic [ISSUE_WIDTH*PAYLOAD_W-1:0] w_src_payload;
    logic [AL_PTR_W-1:0]              w_flush_age;
    logic [AL_PTR_W-1:0]              w_lane_age;
    logic [ISSUE_WIDTH-1:0]           w_kill;
    logic [ISSUE_WIDTH-1:0]           w_next_valid;
    logic [ISSUE_WIDTH*IQ_PTR_W-1:0]  w_kill_iq_ptr;
    logic [CNT_W-1:0]                 w_next_count;

    always_comb begin
        // Under stall the held lanes are re-captured, so a flush can still kill them.
        w_src_valid   = bus.stall ? r_iss_valid   : bus.sch_valid;
        w_src_iq_ptr  = bus.stall ? r_iss_iq_ptr  : bus.sch_iq_ptr;
        w_src_al_ptr  = bus.stall ? r_iss_al_ptr  : bus.sch_al_ptr;
        w_src_payload = bus.stall ? r_iss_payload : bus.sch_payload;

        // Ages are relative to the active-list head, so wrap is handled by modulo subtraction.
        w_flush_age   = bus.flush_al_ptr - bus.al_head_ptr;
        w_lane_age    = '0;
        w_kill        = '0;
        w_kill_iq_ptr = '0;
        w_next_count  = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            w_lane_age = w_src_al_ptr[i*AL_PTR_W +: AL_PTR_W] - bus.al_head_ptr;
            w_kill[i]  = w_src_valid[i] &
                         (bus.flush_all |
                          (bus.flush & ((w_lane_age > w_flush_age) |
                                        (bus.flush_inclusive & (w_lane_age == w_flush_age)))));
            if (w_kill[i]) begin
                w_kill_iq_ptr[i*IQ_PTR_W +: IQ_PTR_W] = w_src_iq_ptr[i*IQ_PTR_W +: IQ_PTR_W];
            end
        end
        w_next_valid = w_src_valid & ~w_kill;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            w_next_count = w_next_count + CNT_W'(w_next_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_valid   <= '0;
            r_iss_iq_ptr  <= '0;
            r_iss_al_ptr  <= '0;
            r_iss_payload <= '0;
            r_kill_mask   <= '0;
            r_kill_iq_ptr <= '0;
            r_valid_count <= '0;
        end else begin
            r_iss_valid   <= w_next_valid;
            r_iss_iq_ptr  <= w_src_iq_ptr;
            r_iss_al_ptr  <= w_src_al_ptr;
            r_iss_payload <= w_src_payload;
            r_kill_mask   <= w_kill;
            r_kill_iq_ptr <= w_kill_iq_ptr;
            r_valid_count <= w_next_count;
        end
    end

    assign bus.iss_valid   = r_iss_valid;
    assign bus.iss_iq_ptr  = r_iss_iq_ptr;
    assign bus.iss_al_ptr  = r_iss_al_ptr;
    assign bus.iss_payload = r_iss_payload;
    assign bus.kill_mask   = r_kill_mask;
    assign bus.kill_iq_ptr = r_kill_iq_ptr;
    assign bus.valid_count = r_valid_count;
endmodule

// File: tb/tb_int_issue_stage_reg.sv
// Scoreboard bench for int_issue_stage_reg: directed recovery scenarios then
// random traffic, checked against an age-arithmetic lane model.
module tb_int_issue_stage_reg;
    localparam int IW  = 2;
    localparam int ALW = 6;
    localparam int IQW = 6;
    localparam int PLW = 64;
    localparam int MOD = 1 << ALW;

    typedef struct {
        logic [IW-1:0]     v;
        logic [IW*IQW-1:0] iq;
        logic [IW*ALW-1:0] al;
        logic [IW*PLW-1:0] pl;
        logic [IW-1:0]     km;
        logic [IW*IQW-1:0] kiq;
        logic [1:0]        cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t q[$];

    // Reference model state: one held entry per lane
    bit           m_v  [IW];
    int           m_iq [IW];
    int           m_al [IW];
    logic [63:0]  m_pl [IW];

    int_issue_stage_reg_if #(.ISSUE_WIDTH(IW), .AL_PTR_W(ALW), .IQ_PTR_W(IQW), .PAYLOAD_W(PLW)) bus ();

    int_issue_stage_reg #(
        .ISSUE_WIDTH(IW),
        .AL_PTR_W   (ALW),
        .IQ_PTR_W   (IQW),
        .PAYLOAD_W  (PLW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("iss_valid", 128'(bus.iss_valid), 128'(e.v));
            chk("kill_mask", 128'(bus.kill_mask), 128'(e.km));
            chk("valid_count", 128'(bus.valid_count), 128'(e.cnt));
            for (int l = 0; l < IW; l++) begin
                if (e.v[l]) begin
                    chk($sformatf("lane%0d iq_ptr", l), 128'(bus.iss_iq_ptr[l*IQW +: IQW]), 128'(e.iq[l*IQW +: IQW]));
                    chk($sformatf("lane%0d al_ptr", l), 128'(bus.iss_al_ptr[l*ALW +: ALW]), 128'(e.al[l*ALW +: ALW]));
                    chk($sformatf("lane%0d payload", l), 128'(bus.iss_payload[l*PLW +: PLW]), 128'(e.pl[l*PLW +: PLW]));
                end
                if (e.km[l]) begin
                    chk($sformatf("lane%0d kill_iq_ptr", l), 128'(bus.kill_iq_ptr[l*IQW +: IQW]), 128'(e.kiq[l*IQW +: IQW]));
                end
            end
        end
    end

    // Drive one cycle of inputs, predict the registered result, advance a clock.
    task automatic step(input bit r, input int sv, input int iq0, input int iq1,
                        input int al0, input int al1, input bit st, input bit fl,
                        input bit fa, input bit finc, input int fptr, input int head);
        exp_t e;
        int   siq [IW];
        int   sal [IW];
        logic [63:0] spl [IW];
        int   age_f;
        int   age_l;
        bit   sv_b;
        bit   doomed;
        int   nvalid;
        siq[0] = iq0; siq[1] = iq1;
        sal[0] = al0; sal[1] = al1;
        spl[0] = {$urandom, $urandom};
        spl[1] = {$urandom, $urandom};

        rst                 = r;
        bus.sch_valid       = IW'(sv);
        bus.sch_iq_ptr      = {IQW'(iq1), IQW'(iq0)};
        bus.sch_al_ptr      = {ALW'(al1), ALW'(al0)};
        bus.sch_payload     = {spl[1], spl[0]};
        bus.stall           = st;
        bus.flush           = fl;
        bus.flush_all       = fa;
        bus.flush_inclusive = finc;
        bus.flush_al_ptr    = ALW'(fptr);
        bus.al_head_ptr     = ALW'(head);

        e.v = '0; e.iq = '0; e.al = '0; e.pl = '0; e.km = '0; e.kiq = '0;
        nvalid = 0;
        age_f  = ((fptr - head) % MOD + MOD) % MOD;
        for (int l = 0; l < IW; l++) begin
            if (r) begin
                m_v[l] = 1'b0; m_iq[l] = 0; m_al[l] = 0; m_pl[l] = '0;
            end else begin
                if (!st) begin
                    sv_b = bit'((sv >> l) & 1);
                    m_v[l] = sv_b; m_iq[l] = siq[l]; m_al[l] = sal[l]; m_pl[l] = spl[l];
                end
                age_l  = ((m_al[l] - head) % MOD + MOD) % MOD;
                doomed = fa || (fl && (age_l > age_f || (age_l == age_f && finc)));
                if (m_v[l] && doomed) begin
                    e.km[l] = 1'b1;
                    e.kiq[l*IQW +: IQW] = IQW'(m_iq[l]);
                    m_v[l] = 1'b0;
                end
            end
            e.v[l] = m_v[l];
            e.iq[l*IQW +: IQW] = IQW'(m_iq[l]);
            e.al[l*ALW +: ALW] = ALW'(m_al[l]);
            e.pl[l*PLW +: PLW] = m_pl[l];
            nvalid += int'(m_v[l]);
        end
        e.cnt = 2'(nvalid);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // Reset with valid lanes presented, then one lane after release
        step(1, 3, 1, 2, 5, 6, 0, 0, 0, 0, 0, 0);
        step(0, 1, 7, 8, 5, 6, 0, 0, 0, 0, 0, 0);
        // Stall hold for three cycles while sch_* churns, then release
        step(0, 3, 11, 12, 3, 4, 0, 0, 0, 0, 0, 0);
        step(0, 3, 21, 22, 30, 31, 1, 0, 0, 0, 0, 0);
        step(0, 0, 23, 24, 32, 33, 1, 0, 0, 0, 0, 0);
        step(0, 2, 25, 26, 34, 35, 1, 0, 0, 0, 0, 0);
        step(0, 3, 13, 14, 40, 41, 0, 0, 0, 0, 0, 0);
        // Selective flush across head wrap on stalled lanes
        step(0, 3, 15, 16, 63, 1, 0, 0, 0, 0, 0, 62);
        step(0, 3, 50, 51, 2, 3, 1, 1, 0, 0, 0, 62);
        step(0, 3, 50, 51, 2, 3, 1, 0, 0, 0, 0, 62);
        // Inclusive boundary on incoming lanes
        step(0, 3, 17, 18, 10, 9, 0, 1, 0, 1, 10, 8);
        step(0, 3, 17, 18, 10, 9, 0, 1, 0, 0, 10, 8);
        // flush_all while stalled, held two cycles
        step(0, 3, 19, 20, 20, 21, 0, 0, 0, 0, 0, 0);
        step(0, 3, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0);
        step(0, 3, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0);
        // Flush filtering incoming lanes
        step(0, 3, 27, 28, 7, 9, 0, 1, 0, 0, 8, 0);
        // Invalid lanes with matching pointers never report a kill
        step(0, 0, 29, 30, 9, 9, 0, 1, 1, 1, 9, 0);
        // Reset dominates flush_all and stall
        step(0, 3, 31, 32, 33, 34, 0, 0, 0, 0, 0, 0);
        step(1, 3, 31, 32, 33, 34, 1, 1, 1, 1, 0, 0);

        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 49) == 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0,
                 bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        end

        @(negedge clk);
        #1;
        chk("scoreboard drained", 128'(q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
